// File: rtl/gfx_arb_pkg.sv
// Shared types and default widths for the frame-buffer arbiter and the pixel data-gen engines.
package gfx_arb_pkg;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } gfx_op_e;

   localparam int GFX_NUM_REQ   = 4;
   localparam int GFX_ADDR_W    = 16;
   localparam int GFX_DATA_W    = 32;
   localparam int GFX_RD_DEPTH  = 4;
   localparam int GFX_BURST_MAX = 16;

   // Requester id width; never zero so a lone requester still has a usable id bus.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gfx_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding reads; push and pop may share a cycle, even at full.
module gfx_arb_tag_fifo
   import gfx_arb_pkg::*;
#(
   parameter int DEPTH = GFX_RD_DEPTH,
   parameter int ID_W  = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             push,
   input  logic [ID_W-1:0]  push_id,
   input  logic             pop,
   output logic [ID_W-1:0]  head_id,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign count   = cnt_q;
   assign head_id = mem_q[rd_ptr_q];

   // A push at full is only legal alongside a pop; the head is read before the slot is reused.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_id;
   end

endmodule

// File: rtl/gfx_mem_arbiter.sv
// Round-robin arbiter sharing one frame-buffer port among NUM_REQ engines, with read-data return routing.
// Optional burst lock (stay with the current owner up to BURST_MAX beats): define GFX_ARB_BURST_LOCK_EN.
module gfx_mem_arbiter
   import gfx_arb_pkg::*;
#(
   parameter int NUM_REQ   = GFX_NUM_REQ,
   parameter int ADDR_W    = GFX_ADDR_W,
   parameter int DATA_W    = GFX_DATA_W,
   parameter int RD_DEPTH  = GFX_RD_DEPTH,
   parameter int BURST_MAX = GFX_BURST_MAX,
   localparam int BE_W  = DATA_W / 8,
   localparam int ID_W  = id_w(NUM_REQ),
   localparam int CNT_W = $clog2(RD_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic [NUM_REQ-1:0]         req_rts,
   output logic [NUM_REQ-1:0]         req_rtr,
   input  logic [NUM_REQ*BE_W-1:0]    req_wben,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ-1:0]         req_op,
   output logic                       mem_out_rts,
   input  logic                       mem_in_rtr,
   output logic [BE_W-1:0]            mem_out_wben,
   output logic [ADDR_W-1:0]          mem_out_addr,
   output logic [DATA_W-1:0]          mem_out_data,
   output logic                       mem_out_op,
   input  logic                       mem_in_rd_valid,
   input  logic [DATA_W-1:0]          mem_in_rd_data,
   output logic [DATA_W-1:0]          bcast_out_data,
   output logic [NUM_REQ-1:0]         bcast_out_xfc,
   output logic                       arb_is_idle,
   output logic                       rd_underflow
);

   logic [BE_W-1:0]    wben_a [NUM_REQ];
   logic [ADDR_W-1:0]  addr_a [NUM_REQ];
   logic [DATA_W-1:0]  data_a [NUM_REQ];
   logic [NUM_REQ-1:0] elig;
   logic               rd_ok;

   logic               mem_out_rts_q, mem_out_rts_d;
   logic [BE_W-1:0]    mem_out_wben_q, mem_out_wben_d;
   logic [ADDR_W-1:0]  mem_out_addr_q, mem_out_addr_d;
   logic [DATA_W-1:0]  mem_out_data_q, mem_out_data_d;
   logic               mem_out_op_q, mem_out_op_d;
   logic [ID_W-1:0]    slot_id_q, slot_id_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [DATA_W-1:0]  bcast_data_q, bcast_data_d;
   logic [NUM_REQ-1:0] bcast_xfc_q, bcast_xfc_d;
   logic               underflow_q, underflow_d;

   logic               slot_free, req_xfer, mem_xfer;
   logic               win_vld;
   logic [ID_W-1:0]    win_id;

   logic               tag_push, tag_pop, tag_empty, tag_full;
   logic [ID_W-1:0]    tag_head;
   logic [CNT_W-1:0]   tag_count;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign wben_a[i] = req_wben[i*BE_W +: BE_W];
      assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign data_a[i] = req_data[i*DATA_W +: DATA_W];
      assign elig[i]   = req_rts[i] & ((req_op[i] == OP_WRITE) | rd_ok);
   end

   // A read sitting in the slot has already claimed a tag entry.
   assign rd_ok     = (32'(tag_count) + 32'(mem_out_rts_q & mem_out_op_q)) < 32'(RD_DEPTH);
   assign slot_free = ~mem_out_rts_q | mem_in_rtr;
   assign mem_xfer  = mem_out_rts_q & mem_in_rtr;
   assign req_xfer  = win_vld & slot_free;

`ifdef GFX_ARB_BURST_LOCK_EN
   localparam int BC_W = $clog2(BURST_MAX + 1);
   logic [BC_W-1:0] burst_cnt_q, burst_cnt_d;
   logic            lock_hold;

   // ptr_q is the current owner; the lock holds while it stays eligible and under the beat cap.
   assign lock_hold = (burst_cnt_q != '0) && (burst_cnt_q < BC_W'(BURST_MAX)) && elig[ptr_q];

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (req_xfer)          burst_cnt_d = lock_hold ? burst_cnt_q + BC_W'(1) : BC_W'(1);
      else if (!elig[ptr_q]) burst_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) burst_cnt_q <= '0;
      else       burst_cnt_q <= burst_cnt_d;
   end
`endif

   // Scan downward so the candidate closest after ptr is the last one written.
   always_comb begin
      logic [ID_W-1:0] idx;
      idx     = '0;
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (elig[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
`ifdef GFX_ARB_BURST_LOCK_EN
      if (lock_hold) begin
         win_vld = 1'b1;
         win_id  = ptr_q;
      end
`endif
   end

   always_comb begin
      req_rtr = '0;
      if (req_xfer) req_rtr[win_id] = 1'b1;
   end

   always_comb begin
      mem_out_rts_d  = mem_out_rts_q;
      mem_out_wben_d = mem_out_wben_q;
      mem_out_addr_d = mem_out_addr_q;
      mem_out_data_d = mem_out_data_q;
      mem_out_op_d   = mem_out_op_q;
      slot_id_d      = slot_id_q;
      ptr_d          = ptr_q;
      if (req_xfer) begin
         mem_out_rts_d  = 1'b1;
         mem_out_wben_d = wben_a[win_id];
         mem_out_addr_d = addr_a[win_id];
         mem_out_data_d = data_a[win_id];
         mem_out_op_d   = req_op[win_id];
         slot_id_d      = win_id;
         ptr_d          = win_id;
      end else if (mem_xfer) begin
         mem_out_rts_d  = 1'b0;
      end
   end

   assign tag_push = mem_xfer & mem_out_op_q;
   assign tag_pop  = mem_in_rd_valid & ~tag_empty;

   always_comb begin
      bcast_xfc_d  = '0;
      bcast_data_d = bcast_data_q;
      underflow_d  = underflow_q | (mem_in_rd_valid & tag_empty);
      if (tag_pop) begin
         bcast_xfc_d[tag_head] = 1'b1;
         bcast_data_d          = mem_in_rd_data;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         mem_out_rts_q  <= 1'b0;
         mem_out_wben_q <= '0;
         mem_out_addr_q <= '0;
         mem_out_data_q <= '0;
         mem_out_op_q   <= 1'b0;
         slot_id_q      <= '0;
         ptr_q          <= ID_W'(NUM_REQ - 1);
         bcast_data_q   <= '0;
         bcast_xfc_q    <= '0;
         underflow_q    <= 1'b0;
      end else begin
         mem_out_rts_q  <= mem_out_rts_d;
         mem_out_wben_q <= mem_out_wben_d;
         mem_out_addr_q <= mem_out_addr_d;
         mem_out_data_q <= mem_out_data_d;
         mem_out_op_q   <= mem_out_op_d;
         slot_id_q      <= slot_id_d;
         ptr_q          <= ptr_d;
         bcast_data_q   <= bcast_data_d;
         bcast_xfc_q    <= bcast_xfc_d;
         underflow_q    <= underflow_d;
      end
   end

   gfx_arb_tag_fifo #(
      .DEPTH (RD_DEPTH),
      .ID_W  (ID_W)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_    (rst_),
      .push    (tag_push),
      .push_id (slot_id_q),
      .pop     (tag_pop),
      .head_id (tag_head),
      .count   (tag_count),
      .empty   (tag_empty),
      .full    (tag_full)
   );

   assign mem_out_rts    = mem_out_rts_q;
   assign mem_out_wben   = mem_out_wben_q;
   assign mem_out_addr   = mem_out_addr_q;
   assign mem_out_data   = mem_out_data_q;
   assign mem_out_op     = mem_out_op_q;
   assign bcast_out_data = bcast_data_q;
   assign bcast_out_xfc  = bcast_xfc_q;
   assign rd_underflow   = underflow_q;
   assign arb_is_idle    = ~mem_out_rts_q & (tag_count == '0) & ~(|req_rts);

endmodule
